// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: captures ALU result, branch outcome, store data and MEM/WB controls,
// with hazard-unit stall (hold) and flush (bubble) control plus MEM-stage forwarding hit detection.
module ex_mem_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    input  logic [DATA_W-1:0] ex_alu_result_i,
    input  logic              ex_zero_i,
    input  logic [DATA_W-1:0] ex_branch_target_i,
    input  logic [DATA_W-1:0] ex_rt_data_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_mem_write_i,
    input  logic              ex_mem_to_reg_i,
    input  logic              ex_branch_i,
    input  logic              ex_branch_ne_i,
    input  logic [REG_AW-1:0] fwd_rs_addr_i,
    input  logic [REG_AW-1:0] fwd_rt_addr_i,
    output logic              mem_valid_o,
    output logic [DATA_W-1:0] mem_alu_result_o,
    output logic [DATA_W-1:0] mem_branch_target_o,
    output logic [DATA_W-1:0] mem_rt_data_o,
    output logic [REG_AW-1:0] mem_rd_addr_o,
    output logic              mem_reg_write_o,
    output logic              mem_mem_read_o,
    output logic              mem_mem_write_o,
    output logic              mem_mem_to_reg_o,
    output logic              mem_branch_taken_o,
    output logic              fwd_rs_hit_o,
    output logic              fwd_rt_hit_o,
    output logic [7:0]        bubble_cnt_o
);

    // Flow control: stall_i holds every register; flush_i (or an invalid EX slot when not
    // stalled) loads a bubble. Flush beats stall, reset beats both.
    logic load_bubble;
    logic load_ex;
    logic ex_taken;
    logic fwd_src_ok;

    assign load_bubble = flush_i | (~stall_i & ~ex_valid_i);
    assign load_ex     = ~flush_i & ~stall_i & ex_valid_i;
    // Branch outcome is frozen from the zero flag at capture time.
    assign ex_taken    = (ex_branch_i & ex_zero_i) | (ex_branch_ne_i & ~ex_zero_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_valid_o         <= 1'b0;
            mem_alu_result_o    <= '0;
            mem_branch_target_o <= '0;
            mem_rt_data_o       <= '0;
            mem_rd_addr_o       <= '0;
            mem_reg_write_o     <= 1'b0;
            mem_mem_read_o      <= 1'b0;
            mem_mem_write_o     <= 1'b0;
            mem_mem_to_reg_o    <= 1'b0;
            mem_branch_taken_o  <= 1'b0;
            bubble_cnt_o        <= 8'd0;
        end else if (load_bubble) begin
            mem_valid_o         <= 1'b0;
            mem_alu_result_o    <= '0;
            mem_branch_target_o <= '0;
            mem_rt_data_o       <= '0;
            mem_rd_addr_o       <= '0;
            mem_reg_write_o     <= 1'b0;
            mem_mem_read_o      <= 1'b0;
            mem_mem_write_o     <= 1'b0;
            mem_mem_to_reg_o    <= 1'b0;
            mem_branch_taken_o  <= 1'b0;
            if (bubble_cnt_o != 8'hFF) begin
                bubble_cnt_o <= bubble_cnt_o + 8'd1;
            end
        end else if (load_ex) begin
            mem_valid_o         <= 1'b1;
            mem_alu_result_o    <= ex_alu_result_i;
            mem_branch_target_o <= ex_branch_target_i;
            mem_rt_data_o       <= ex_rt_data_i;
            mem_rd_addr_o       <= ex_rd_addr_i;
            mem_reg_write_o     <= ex_reg_write_i;
            mem_mem_read_o      <= ex_mem_read_i;
            mem_mem_write_o     <= ex_mem_write_i;
            mem_mem_to_reg_o    <= ex_mem_to_reg_i;
            mem_branch_taken_o  <= ex_taken;
        end
    end

    // Loads have no data yet at this stage and r0 is hardwired, so neither may forward.
    assign fwd_src_ok   = mem_valid_o & mem_reg_write_o & ~mem_mem_read_o & (mem_rd_addr_o != '0);
    assign fwd_rs_hit_o = fwd_src_ok & (mem_rd_addr_o == fwd_rs_addr_i);
    assign fwd_rt_hit_o = fwd_src_ok & (mem_rd_addr_o == fwd_rt_addr_i);

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: directed steps with a reference model feeding an expected queue,
// compared one cycle after each drive, plus directed constant checks on key outputs.
module tb_ex_mem_stage_reg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int OUT_W  = 1 + 3 * DATA_W + REG_AW + 4 + 1 + 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              stall, flush, ex_valid, ex_zero;
    logic [DATA_W-1:0] ex_alu, ex_tgt, ex_rt;
    logic [REG_AW-1:0] ex_rd, fwd_rs, fwd_rt;
    logic              ex_rw, ex_mr, ex_mw, ex_m2r, ex_br, ex_bne;

    logic              mem_valid, mem_rw, mem_mr, mem_mw, mem_m2r, mem_taken;
    logic [DATA_W-1:0] mem_alu, mem_tgt, mem_rt;
    logic [REG_AW-1:0] mem_rd;
    logic              rs_hit, rt_hit;
    logic [7:0]        bubble_cnt;

    ex_mem_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .ex_valid_i(ex_valid), .ex_alu_result_i(ex_alu), .ex_zero_i(ex_zero),
        .ex_branch_target_i(ex_tgt), .ex_rt_data_i(ex_rt), .ex_rd_addr_i(ex_rd),
        .ex_reg_write_i(ex_rw), .ex_mem_read_i(ex_mr), .ex_mem_write_i(ex_mw),
        .ex_mem_to_reg_i(ex_m2r), .ex_branch_i(ex_br), .ex_branch_ne_i(ex_bne),
        .fwd_rs_addr_i(fwd_rs), .fwd_rt_addr_i(fwd_rt),
        .mem_valid_o(mem_valid), .mem_alu_result_o(mem_alu), .mem_branch_target_o(mem_tgt),
        .mem_rt_data_o(mem_rt), .mem_rd_addr_o(mem_rd), .mem_reg_write_o(mem_rw),
        .mem_mem_read_o(mem_mr), .mem_mem_write_o(mem_mw), .mem_mem_to_reg_o(mem_m2r),
        .mem_branch_taken_o(mem_taken), .fwd_rs_hit_o(rs_hit), .fwd_rt_hit_o(rt_hit),
        .bubble_cnt_o(bubble_cnt)
    );

    logic [OUT_W-1:0] dut_out;
    assign dut_out = {mem_valid, mem_alu, mem_tgt, mem_rt, mem_rd,
                      mem_rw, mem_mr, mem_mw, mem_m2r, mem_taken, bubble_cnt};

    // ---------------- reference model state ----------------
    logic              m_valid, m_rw, m_mr, m_mw, m_m2r, m_taken;
    logic [DATA_W-1:0] m_alu, m_tgt, m_rt;
    logic [REG_AW-1:0] m_rd;
    logic [7:0]        m_cnt;

    logic [OUT_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [OUT_W-1:0] model_vec();
        return {m_valid, m_alu, m_tgt, m_rt, m_rd, m_rw, m_mr, m_mw, m_m2r, m_taken, m_cnt};
    endfunction

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear_fields();
        m_valid = 1'b0; m_alu = '0; m_tgt = '0; m_rt = '0; m_rd = '0;
        m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0; m_taken = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic rand_ex();
        ex_valid = 1'($urandom_range(0, 1));
        ex_alu   = $urandom; ex_tgt = $urandom; ex_rt = $urandom;
        ex_zero  = 1'($urandom_range(0, 1));
        ex_rd    = REG_AW'($urandom_range(0, 31));
        ex_rw    = 1'($urandom_range(0, 1)); ex_mr  = 1'($urandom_range(0, 1));
        ex_mw    = 1'($urandom_range(0, 1)); ex_m2r = 1'($urandom_range(0, 1));
        ex_br    = 1'($urandom_range(0, 1)); ex_bne = 1'($urandom_range(0, 1));
    endtask

    task automatic set_instr(input logic [DATA_W-1:0] alu, input logic [REG_AW-1:0] rd,
                             input logic rw, input logic mr, input logic br, input logic bne,
                             input logic zero, input logic [DATA_W-1:0] tgt);
        ex_valid = 1'b1; ex_alu = alu; ex_rd = rd; ex_rw = rw; ex_mr = mr;
        ex_mw = 1'b0; ex_m2r = mr; ex_br = br; ex_bne = bne; ex_zero = zero;
        ex_tgt = tgt; ex_rt = 32'hA5A5_0000 | {27'd0, rd};
    endtask

    // Predict the next register contents, clock once, then compare against the queue head.
    task automatic step(input string tag);
        if (rst) begin
            model_clear_fields();
            m_cnt = 8'd0;
        end else if (flush || (!stall && !ex_valid)) begin
            model_clear_fields();
            if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        end else if (!stall) begin
            m_valid = 1'b1; m_alu = ex_alu; m_tgt = ex_tgt; m_rt = ex_rt; m_rd = ex_rd;
            m_rw = ex_rw; m_mr = ex_mr; m_mw = ex_mw; m_m2r = ex_m2r;
            m_taken = (ex_br & ex_zero) | (ex_bne & ~ex_zero);
        end
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) check({tag, "_empty_q"}, 1, 0);
        else check(tag, dut_out, exp_q.pop_front());
    endtask

    task automatic check_fwd(input string tag);
        logic ok;
        ok = m_valid & m_rw & ~m_mr & (m_rd != '0);
        check({tag, "_rs"}, OUT_W'(rs_hit), OUT_W'(ok & (m_rd == fwd_rs)));
        check({tag, "_rt"}, OUT_W'(rt_hit), OUT_W'(ok & (m_rd == fwd_rt)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [OUT_W-1:0] frozen;
        logic [7:0]       cnt_before;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; fwd_rs = '0; fwd_rt = '0;
        model_clear_fields(); m_cnt = 8'd0;

        // reset with random EX contents
        rand_ex(); step("rst_cyc1");
        rand_ex(); step("rst_cyc2");
        check("rst_all_zero", dut_out, '0);

        // first real instruction after release
        rst = 1'b0;
        set_instr(32'h0000_0007, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("first_add");
        check("first_add_fields", OUT_W'({mem_valid, mem_alu, mem_rd}), OUT_W'({1'b1, 32'h7, 5'd3}));

        // branch resolution
        set_instr(32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040);
        step("beq_taken");
        check("beq_taken_val", OUT_W'({mem_taken, mem_tgt}), OUT_W'({1'b1, 32'h40}));
        set_instr(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
        step("bne_not_taken");
        check("bne_zero1_val", OUT_W'(mem_taken), OUT_W'(0));
        set_instr(32'h1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0084);
        step("bne_taken");
        check("bne_zero0_val", OUT_W'(mem_taken), OUT_W'(1));
        set_instr(32'h1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0088);
        step("beq_bne_both");
        check("both_or_val", OUT_W'(mem_taken), OUT_W'(1));

        // stall for 3 cycles while EX keeps changing
        set_instr(32'h1234_5678, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("pre_stall");
        frozen = model_vec();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            step("stall_hold");
        end
        check("stall_frozen", dut_out, frozen);
        check("stall_alu_const", OUT_W'(mem_alu), OUT_W'(32'h1234_5678));

        // flush and stall together
        cnt_before = m_cnt;
        flush = 1'b1;
        set_instr(32'hDEAD_BEEF, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("flush_stall");
        check("flush_stall_bubble", OUT_W'({mem_valid, mem_rw, mem_mr, mem_mw, mem_m2r, mem_taken}), '0);
        check("flush_stall_cnt", OUT_W'(bubble_cnt), OUT_W'(cnt_before + 8'd1));
        flush = 1'b0; stall = 1'b0;

        // forwarding detection
        set_instr(32'h0000_00AA, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("fwd_load_rd5");
        fwd_rs = 5'd5; fwd_rt = 5'd6; #1;
        check("fwd_rs_hit", OUT_W'(rs_hit), OUT_W'(1));
        check("fwd_rt_miss", OUT_W'(rt_hit), OUT_W'(0));
        set_instr(32'h0000_00AB, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step("fwd_load_memread");
        check("fwd_memread_no_hit", OUT_W'(rs_hit), OUT_W'(0));
        set_instr(32'h0000_00AC, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        fwd_rs = 5'd0; fwd_rt = 5'd0;
        step("fwd_load_rd0");
        check("fwd_rd0_no_hit", OUT_W'({rs_hit, rt_hit}), OUT_W'(0));

        // invalid EX slot loads a bubble
        ex_valid = 1'b0;
        step("invalid_bubble");

        // reset in the middle of a stall holding a valid instruction
        set_instr(32'h0000_0055, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("pre_rst_stall");
        stall = 1'b1; rst = 1'b1;
        step("rst_in_stall");
        check("rst_in_stall_zero", dut_out, '0);
        rst = 1'b0; stall = 1'b0;

        // bubble counter saturation
        flush = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_ex();
            step("flush_run");
        end
        check("cnt_saturated", OUT_W'(bubble_cnt), OUT_W'(8'd255));
        flush = 1'b0;

        // randomised mix of stall/flush/valid with occasional reset
        for (int i = 0; i < 150; i++) begin
            rand_ex();
            stall  = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 5) == 0);
            rst    = ($urandom_range(0, 40) == 0);
            fwd_rs = REG_AW'($urandom_range(0, 7));
            fwd_rt = REG_AW'($urandom_range(0, 7));
            ex_rd  = REG_AW'($urandom_range(0, 7));
            step("random_mix");
            check_fwd("random_fwd");
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
